// File: rtl/protocol_spi_slave.sv
// ============================================================================
//  protocol_spi_slave -- SPI mode-0 responder, MSB first, pins synchronized
//  into the clk domain and edge-detected.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module protocol_spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              tx_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              busy
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [0:0]        S_IDLE   = 1'b0;
    localparam logic [0:0]        S_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              done_q, done_d;
    logic              tx_ack_q, tx_ack_d;

    logic              w_sclk_s, w_ss_s, w_mosi_s;
    logic              w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic              w_start, w_abort, w_rx_step, w_tx_step;
    logic [DATA_W-1:0] w_rx_next;

    // Edges compare the last synchronizer stage against one extra registered copy
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign w_ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~sclk_prev_q;
    assign w_sclk_fall = ~w_sclk_s &  sclk_prev_q;
    assign w_ss_rise   =  w_ss_s   & ~ss_prev_q;
    assign w_ss_fall   = ~w_ss_s   &  ss_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_ss_fall) state_d = S_ACTIVE;
            S_ACTIVE: if (w_ss_rise) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // A releasing ss takes priority over any sclk edge seen in the same cycle
    always_comb begin
        w_start   = 1'b0;
        w_abort   = 1'b0;
        w_rx_step = 1'b0;
        w_tx_step = 1'b0;
        miso      = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_start = w_ss_fall;
            end
            S_ACTIVE: begin
                busy      = 1'b1;
                miso      = tx_shift_q[DATA_W-1];
                w_abort   = w_ss_rise;
                w_rx_step = ~w_ss_rise & w_sclk_rise;
                w_tx_step = ~w_ss_rise & w_sclk_fall;
            end
            default: ;
        endcase
    end

    assign w_rx_next = {rx_shift_q[DATA_W-2:0], w_mosi_s};

    always_comb begin
        tx_buf_d   = load ? data_in : tx_buf_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        data_out_d = data_out_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;
        tx_ack_d   = 1'b0;
        if (w_start) begin
            tx_shift_d = tx_buf_q;
            tx_ack_d   = 1'b1;
            bit_cnt_d  = '0;
        end
        if (w_abort) begin
            bit_cnt_d = '0;
        end
        if (w_rx_step) begin
            rx_shift_d = w_rx_next;
            if (bit_cnt_q == CNT_LAST) begin
                bit_cnt_d  = '0;
                data_out_d = w_rx_next;
                done_d     = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
        // Falling edge at a byte boundary reloads from the (old) buffer value
        if (w_tx_step) begin
            if (bit_cnt_q != '0) begin
                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end else begin
                tx_shift_d = tx_buf_q;
                tx_ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_buf_q   <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            data_out_q <= '0;
            bit_cnt_q  <= '0;
            done_q     <= 1'b0;
            tx_ack_q   <= 1'b0;
        end else begin
            tx_buf_q   <= tx_buf_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            data_out_q <= data_out_d;
            bit_cnt_q  <= bit_cnt_d;
            done_q     <= done_d;
            tx_ack_q   <= tx_ack_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign tx_ack   = tx_ack_q;

endmodule

`default_nettype wire
